auto_player: RTL and testbench
==============================

Name: auto_player

Overview:
- Automated opponent for the tennis game; the responder to the `top` LED/ball interface.
- Watches the 16-bit `led` ball-position bus that `top` drives.
- Produces a button press (`but_1` or `but_2` of `top`) with a configurable reaction delay and a pseudo-random miss rate.
- Lets one human play against the board, or lets a bench run rallies without hand-timed stimulus.

Parameters:
- LED_W, 16, width of the ball-position bus.
- HIT_IDX, 15, LED bit marking this player's hit zone.
- REACT_CYCLES, 4, clocks from hit-zone entry to button assertion; minimum 1.
- PRESS_CYCLES, 2, clocks the button is held high; minimum 1.
- MISS_THRESH, 8'd32, deliberate miss when lfsr[7:0] < MISS_THRESH; 0 = never miss.
- SERVE_WAIT, 64, clocks the ball must sit parked in the hit zone before an auto-serve press.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock.
- reset_clk  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- enable  input  1  1 = auto-player active; 0 = forced to WATCH with button low.
- led  input  LED_W  ball position from `top`, nominally one-hot.
- but  output  1  button press toward `top`.
- hits  output  8  count of presses issued, saturating at 255.
- misses  output  8  count of deliberate misses, saturating at 255.
- state_dbg  output  3  current FSM state encoding.

Behaviour:
- Reset (reset_clk==0 at a clk edge):
  - state=WATCH; but=0; hits=0; misses=0.
  - lfsr=LFSR_SEED; all counters and the zone_q history bit cleared.
  - Overrides every other input.
- Reset asserted mid-press: but is 0 from the next edge.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; shifts every clk while out of reset, regardless of state.
  - Never reaches 0.
- zone = led[HIT_IDX]. zone_q is zone registered one cycle. Rising entry = zone & ~zone_q. Other led bits are ignored.
- FSM (all outputs registered):
  - WATCH:
    - On rising entry, if lfsr[7:0] < MISS_THRESH: misses++ and go to MISSED. Otherwise load react counter and go to WAIT.
    - If zone has been high continuously for SERVE_WAIT cycles while in WATCH (parked ball awaiting serve): go to PRESS directly.
  - WAIT: react counter decrements; at terminal count go to PRESS.
  - PRESS: but=1 for exactly PRESS_CYCLES cycles; hits++ once on entry; then go to HOLDOFF.
  - HOLDOFF and MISSED: wait for zone==0, then go to WATCH. No re-trigger while the ball stays in the zone.
- Latency: zone sampled 0 at edge k-1 and 1 at edge k (non-miss) → but==1 after edges k+REACT_CYCLES .. k+REACT_CYCLES+PRESS_CYCLES-1, and 0 otherwise.
- The park counter resets whenever zone==0 or state≠WATCH. It saturates, so a parked ball produces one serve press per HOLDOFF exit.
- enable==0: next state WATCH, but=0, counters hold, LFSR keeps running. On re-enable, a ball already in the zone does not count as a rising entry (zone_q keeps tracking during disable).
- Ball leaves the zone during WAIT or PRESS: the sequence still completes (the press is late, `top` decides the outcome), then HOLDOFF exits immediately.
- led all-zero or multi-hot: only bit HIT_IDX matters; no error state.
- Counters saturate at 255 and never wrap.
- state_dbg encoding: WATCH=0, WAIT=1, PRESS=2, HOLDOFF=3, MISSED=4.

Decomposition:
- Shared package `tennis_pkg` holds:
  - state enum/localparams (WATCH..MISSED);
  - LED_W default;
  - LFSR tap mask constant.
- One natural sub-module, `lfsr8`: clk, reset_clk, seed parameter, 8-bit output. `top`'s serve logic can reuse it.
- Everything else stays in auto_player.

Test Plan:
- Reset then a single pulse:
  - Setup: reset_clk=0 for 2 cycles, then 1; enable=1, MISS_THRESH=0, REACT=4, PRESS=2.
  - Stimulus: led=16'h8000 rising at edge 10.
  - Expect: but=1 after edges 14 and 15, 0 at 16; hits=1; state_dbg returns to 0 once led=0.
- Miss path:
  - Setup: MISS_THRESH=8'd255, LFSR_SEED=8'h01.
  - Stimulus: three separate entries of led[15].
  - Expect: but stays 0 throughout; misses=3; hits=0.
- Auto-serve:
  - Setup: SERVE_WAIT=8.
  - Stimulus: hold led=16'h8000 from reset.
  - Expect: but high for 2 cycles after 8 parked cycles; only one press while led stays 16'h8000.
- Disable mid-WAIT:
  - Stimulus: enable=0 two cycles after entry.
  - Expect: but never asserts; state_dbg=0.
  - Stimulus: re-enable with the ball still in the zone.
  - Expect: no press until led leaves and re-enters.
- Reset during PRESS:
  - Stimulus: reset_clk=0 on the first press cycle.
  - Expect: but=0 next edge; hits=0; misses=0.
- Saturation:
  - Stimulus: 300 entry/exit cycles of led[15] with MISS_THRESH=0.
  - Expect: hits=255 and no wrap.

Source files
------------

// File: rtl/tennis_pkg.sv
// Shared definitions for the tennis game blocks: FSM state codes,
// default ball-bus width and the LFSR feedback tap mask.
package tennis_pkg;

  localparam int unsigned LED_W_DEF = 16;

  // 8-bit Fibonacci LFSR taps 8,6,5,4 -> register bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // auto_player FSM state encoding (also driven out on state_dbg).
  localparam logic [2:0] ST_WATCH   = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_PRESS   = 3'd2;
  localparam logic [2:0] ST_HOLDOFF = 3'd3;
  localparam logic [2:0] ST_MISSED  = 3'd4;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4).
// Ports:
//   clk       - system clock
//   reset_clk - synchronous active-low reset, loads SEED
//   lfsr_o    - current LFSR value (never zero for a nonzero SEED)
module lfsr8
  import tennis_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_clk,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift left, feedback is the XOR of the tapped bits.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (!reset_clk) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/auto_player.sv
// Automated tennis opponent: watches the ball-position bus and presses
// the button after a reaction delay, with a pseudo-random miss rate and
// an auto-serve when the ball sits parked in the hit zone.
// Ports:
//   clk       - system clock
//   reset_clk - synchronous active-low reset
//   enable    - 1 = active, 0 = forced to WATCH with button low
//   led       - ball position bus (only bit HIT_IDX is used)
//   but       - registered button press
//   hits      - presses issued, saturating at 255
//   misses    - deliberate misses, saturating at 255
//   state_dbg - current FSM state code
module auto_player
  import tennis_pkg::*;
#(
  parameter int unsigned LED_W        = LED_W_DEF,
  parameter int unsigned HIT_IDX      = 15,
  parameter int unsigned REACT_CYCLES = 4,
  parameter int unsigned PRESS_CYCLES = 2,
  parameter logic [7:0]  MISS_THRESH  = 8'd32,
  parameter int unsigned SERVE_WAIT   = 64,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic             clk,
  input  logic             reset_clk,
  input  logic             enable,
  input  logic [LED_W-1:0] led,
  output logic             but,
  output logic [7:0]       hits,
  output logic [7:0]       misses,
  output logic [2:0]       state_dbg
);

  localparam int unsigned CNT_MAX = (REACT_CYCLES > PRESS_CYCLES) ? REACT_CYCLES : PRESS_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PK_W    = $clog2(SERVE_WAIT + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PK_W-1:0]  park_q, park_d;
  logic [7:0]       hits_q, hits_d;
  logic [7:0]       misses_q, misses_d;
  logic             but_q, but_d;
  logic             zone_q;

  logic [7:0]       lfsr_c;
  logic             zone_c;
  logic             rise_c;
  logic             miss_c;
  logic [7:0]       unused_diff;
  logic             unused_led;

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset_clk (reset_clk),
    .lfsr_o    (lfsr_c)
  );

  assign zone_c     = led[HIT_IDX];
  assign rise_c     = zone_c & ~zone_q;
  assign unused_led = ^led;

  // lfsr < MISS_THRESH taken as the borrow of a 9-bit subtraction.
  assign {miss_c, unused_diff} = 9'(lfsr_c) - 9'(MISS_THRESH);

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    park_d   = '0;
    hits_d   = hits_q;
    misses_d = misses_q;

    if (!enable) begin
      state_d = ST_WATCH;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_WATCH: begin
          if (rise_c) begin
            if (miss_c) begin
              state_d = ST_MISSED;
              if (misses_q != 8'hFF) misses_d = misses_q + 8'd1;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = CNT_W'(REACT_CYCLES - 1);
            end
          end else if (zone_c) begin
            // Parked ball: serve once it has sat SERVE_WAIT sampled cycles.
            if (park_q == PK_W'(SERVE_WAIT - 1)) begin
              state_d = ST_PRESS;
              cnt_d   = CNT_W'(PRESS_CYCLES - 1);
              if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
            end else begin
              park_d = park_q + PK_W'(1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_d = ST_PRESS;
            cnt_d   = CNT_W'(PRESS_CYCLES - 1);
            if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_PRESS: begin
          if (cnt_q == '0) begin
            state_d = ST_HOLDOFF;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_HOLDOFF, ST_MISSED: begin
          if (!zone_c) state_d = ST_WATCH;
        end
        default: begin
          state_d = ST_WATCH;
          cnt_d   = '0;
        end
      endcase
    end

    but_d = (state_d == ST_PRESS);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_clk) begin
      state_q  <= ST_WATCH;
      cnt_q    <= '0;
      park_q   <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      but_q    <= 1'b0;
      zone_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      park_q   <= park_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      but_q    <= but_d;
      zone_q   <= zone_c;
    end
  end

  assign but       = but_q;
  assign hits      = hits_q;
  assign misses    = misses_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_auto_player.sv
// Directed bench for auto_player: three instances cover the normal-hit
// configuration (a), the always-miss configuration (m) and a short
// auto-serve configuration (s).
module tb_auto_player;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_m, en_s;
  logic [15:0] led_a, led_m, led_s;
  logic        but_a, but_m, but_s;
  logic [7:0]  hits_a, hits_m, hits_s;
  logic [7:0]  miss_a, miss_m, miss_s;
  logic [2:0]  st_a, st_m, st_s;

  logic [7:0]  mdl_lfsr_m;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          exp_h;
  int          cnt;

  always #5 clk = ~clk;

  auto_player #(.MISS_THRESH(8'd0)) dut_a (
    .clk(clk), .reset_clk(rst_n), .enable(en_a), .led(led_a),
    .but(but_a), .hits(hits_a), .misses(miss_a), .state_dbg(st_a));

  auto_player #(.MISS_THRESH(8'd255), .LFSR_SEED(8'h01)) dut_m (
    .clk(clk), .reset_clk(rst_n), .enable(en_m), .led(led_m),
    .but(but_m), .hits(hits_m), .misses(miss_m), .state_dbg(st_m));

  auto_player #(.MISS_THRESH(8'd0), .SERVE_WAIT(8)) dut_s (
    .clk(clk), .reset_clk(rst_n), .enable(en_s), .led(led_s),
    .but(but_s), .hits(hits_s), .misses(miss_s), .state_dbg(st_s));

  // Reference LFSR for dut_m (seed 01, taps 8,6,5,4) to steer entries
  // away from the single non-miss value 8'hFF.
  always @(posedge clk) begin
    if (!rst_n) mdl_lfsr_m <= 8'h01;
    else        mdl_lfsr_m <= {mdl_lfsr_m[6:0],
                               mdl_lfsr_m[7] ^ mdl_lfsr_m[5] ^ mdl_lfsr_m[4] ^ mdl_lfsr_m[3]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b1; en_m = 1'b1; en_s = 1'b0;
    led_a = '0; led_m = '0; led_s = 16'h8000;

    // Reset
    step(); step();
    chk("rst_but_a", 32'(but_a), 0);
    chk("rst_hits_a", 32'(hits_a), 0);
    chk("rst_miss_a", 32'(miss_a), 0);
    chk("rst_st_a", 32'(st_a), 0);
    chk("rst_st_m", 32'(st_m), 0);
    chk("rst_but_s", 32'(but_s), 0);
    rst_n = 1'b1;

    // Non-hit-zone bits are ignored
    led_a = 16'h7FFF;
    repeat (3) step();
    chk("other_bits_st", 32'(st_a), 0);
    chk("other_bits_but", 32'(but_a), 0);
    led_a = '0;
    repeat (2) step();

    // Single pulse: press after edges k+4, k+5
    led_a = 16'h8000;
    for (int j = 0; j < 7; j++) begin
      step();
      chk($sformatf("pulse_but_%0d", j), 32'(but_a), (j == 4 || j == 5) ? 1 : 0);
      if (j == 0) chk("pulse_st_wait", 32'(st_a), 1);
      if (j == 4) chk("pulse_st_press", 32'(st_a), 2);
      if (j == 6) chk("pulse_st_holdoff", 32'(st_a), 3);
    end
    led_a = '0;
    step();
    chk("pulse_st_watch", 32'(st_a), 0);
    chk("pulse_hits", 32'(hits_a), 1);

    // Miss path: three entries, all deliberate misses
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 4 && mdl_lfsr_m == 8'hFF; w++) step();
      led_m = 16'h8000;
      step();
      chk($sformatf("miss_st_%0d", i), 32'(st_m), 4);
      chk($sformatf("miss_but_%0d", i), 32'(but_m), 0);
      led_m = '0;
      step();
      chk($sformatf("miss_back_%0d", i), 32'(st_m), 0);
      step();
    end
    chk("miss_count", 32'(miss_m), 3);
    chk("miss_hits", 32'(hits_m), 0);

    // Auto-serve: ball parked since reset, enable now
    en_s = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step();
      chk($sformatf("serve_but_%0d", j), 32'(but_s), (j == 7 || j == 8) ? 1 : 0);
    end
    chk("serve_st_holdoff", 32'(st_s), 3);
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      if (but_s) cnt++;
    end
    chk("serve_single", 32'(cnt), 0);
    chk("serve_hits", 32'(hits_s), 1);

    // Disable mid-WAIT
    led_a = 16'h8000;
    step();
    chk("dis_st_wait", 32'(st_a), 1);
    step();
    en_a = 1'b0;
    step();
    chk("dis_st_watch", 32'(st_a), 0);
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (but_a || st_a != 3'd0) cnt++;
    end
    chk("dis_quiet", 32'(cnt), 0);
    // Re-enable with ball still in the zone: no entry
    en_a = 1'b1;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (but_a || st_a != 3'd0) cnt++;
    end
    chk("reen_quiet", 32'(cnt), 0);
    led_a = '0;
    step(); step();
    led_a = 16'hFFFF;
    for (int j = 0; j < 7; j++) begin
      step();
      chk($sformatf("reen_but_%0d", j), 32'(but_a), (j == 4 || j == 5) ? 1 : 0);
    end
    led_a = '0;
    step(); step();
    chk("reen_hits", 32'(hits_a), 2);

    // Saturation: 300 entry/exit cycles
    exp_h = 2;
    for (int i = 0; i < 300; i++) begin
      led_a = 16'h8000;
      step();
      led_a = '0;
      repeat (8) step();
      exp_h = (exp_h < 255) ? exp_h + 1 : 255;
      if (i == 100) chk("sat_mid", 32'(hits_a), 32'(exp_h));
    end
    chk("sat_hits", 32'(hits_a), 255);
    chk("sat_misses", 32'(miss_a), 0);

    // Reset during the first press cycle
    led_a = 16'h8000;
    repeat (5) step();
    chk("rstp_but_on", 32'(but_a), 1);
    rst_n = 1'b0;
    step();
    chk("rstp_but", 32'(but_a), 0);
    chk("rstp_hits", 32'(hits_a), 0);
    chk("rstp_misses", 32'(miss_a), 0);
    chk("rstp_st", 32'(st_a), 0);
    chk("rstp_miss_m", 32'(miss_m), 0);
    rst_n = 1'b1;
    led_a = '0;
    step();
    chk("rstp_after", 32'(but_a), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
